dsp16_core: RTL and testbench
=============================

Name: dsp16_core

Overview:
- Reduced DSP16-compatible fixed-point DSP core with an internal 4K x 16 program ROM, loaded byte-wise through a programming port.
- Executes a decided instruction subset: goto, long-immediate register load, multiply-to-accumulator and no-op.
- Provides the DSP16 register file split across RAM-AAU, ROM-AAU and DAU.
- Provides a parallel I/O port with strobes; serial I/O and interrupts are stubbed.

Parameters:
- ROM_AW, 12, program ROM word-address width (4096 words).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- cen  in  1  clock enable; core state advances only when high.
- ext_mode  in  1  reserved; ignored, internal ROM always used.
- pbus_in  in  16  parallel input data.
- pbus_out  out  16  parallel output data.
- pods_n  out  1  parallel output strobe, active-low.
- pids_n  out  1  parallel input strobe, active-low.
- psel  out  1  peripheral select: 0 = pdx0, 1 = pdx1.
- sdo  out  1  serial data out, tied 0.
- ock  out  1  serial clock, tied 0.
- sadd  out  1  serial address, tied 1.
- irq  in  1  interrupt request; ignored.
- iack  out  1  interrupt acknowledge, tied 0.
- prog_addr  in  13  ROM byte address.
- prog_data  in  8  ROM byte.
- prog_we  in  1  ROM write enable.

Behaviour:
- ROM programming:
  - On clk posedge with prog_we=1, independent of rst and cen: write prog_data to word prog_addr[12:1].
  - prog_addr[0]=0 selects the low byte, 1 selects the high byte.
  - ROM contents are not cleared by rst.
- ROM read is asynchronous: ins = rom[pc[11:0]].
- Reset (asynchronous):
  - All registers 0: r0-r3, j, k, rb, re, pt, pr, pi, i, pc, x, y, p, a0, a1, c0-c2, auc, psw.
  - pbus_out=0, pods_n=1, pids_n=1, psel=0, decode state = WORD1.
- Execution: one decode step per clk posedge with cen=1; nothing changes when cen=0.
- Opcode field T = ins[15:11]:
  - 00000/00001 goto: pc <= {pc[15:12], ins[11:0]}.
  - 01010 R=N, two words:
    - WORD1: latch R = ins[9:4]; pc++; state -> WORD2.
    - WORD2: write the current ROM word to register R; pc++; state -> WORD1.
  - 00110 multiply: p <= signed x * signed y (32 bit); a0 <= p_old sign-extended to 36 bits; pc++.
  - Any other T: no-op, pc++.
- R codes (writes; reads for pdx):
  - 0-3 r0-r3; 4 j; 5 k; 6 rb; 7 re; 8 pt; 9 pr; 10 pi; 11 i.
  - 16 x; 17 y; 19 auc; 20 psw; 21 c0; 22 c1; 23 c2.
  - 29 pdx0; 30 pdx1.
  - All other codes: write ignored.
- Register widths: all 16 bit except p (32 bit) and a0/a1 (36 bit). psw and auc store the full 16 bits.
- Parallel output (write to pdx0/pdx1 in WORD2):
  - pbus_out <= N; psel <= R[0]^1 (0 for pdx0, 1 for pdx1).
  - pods_n low for exactly that one cen cycle, high again next cen cycle.
- pc wraps 0xFFFF -> 0x0000; ROM index uses pc[11:0].
- rst mid two-word instruction aborts it; no register write.
- prog_we is normally tied to rst at system level; core behaviour during prog_we=1 with rst=0 is undefined-safe (execution continues).

Decomposition:
- Package dsp16_pkg holds:
  - T opcode constants (GOTO0, GOTO1, RLOAD, MPY).
  - 6-bit R register-code constants.
  - Decode state enum {WORD1, WORD2}.
- One natural sub-module: dsp16_regs, containing the register file, the write-decode by R code, and the pdx strobe logic.
- Top contains ROM, pc/decode FSM and tie-offs.

Test Plan:
1. Program via prog port {0x5000 (R=r0), 0x1234, 0x5010 (R=r1), 0xBEEF, 0x0004 (goto 4), goto-self at 4}, then release rst -> after 20 cycles r0=0x1234, r1=0xBEEF, pc=0x0004 stable.
2. Load x=0x0003, y=0xFFFE (R codes 16/17), then MPY twice -> p=0xFFFFFFFA, a0 low 16 bits=0xFFFA.
3. R=pdx1 with N=0xCAFE -> pbus_out=0xCAFE, psel=1, pods_n low one cycle; pids_n stays 1.
4. Hold cen=0 for 10 cycles mid-program -> pc and all registers frozen; resume gives identical final state to case 1.
5. Assert rst between WORD1 and WORD2 of R=N -> target register stays 0, pc=0, pods_n=1.
6. Write j, k, rb, re, pt, pr, pi, i, auc, psw, c0-c2 each with a distinct value (0x0101·code) -> each reads back that value; an unused R code (e.g. 12) changes nothing.

Source files
------------

// File: rtl/dsp16_pkg.sv
// Shared decode constants for the reduced DSP16 core: opcode field values,
// register codes used by the R=N load, and the two-word decode state.
package dsp16_pkg;

  localparam logic [4:0] T_GOTO0 = 5'b00000;
  localparam logic [4:0] T_GOTO1 = 5'b00001;
  localparam logic [4:0] T_RLOAD = 5'b01010;
  localparam logic [4:0] T_MPY   = 5'b00110;

  localparam logic [5:0] R_R0   = 6'd0;
  localparam logic [5:0] R_R1   = 6'd1;
  localparam logic [5:0] R_R2   = 6'd2;
  localparam logic [5:0] R_R3   = 6'd3;
  localparam logic [5:0] R_J    = 6'd4;
  localparam logic [5:0] R_K    = 6'd5;
  localparam logic [5:0] R_RB   = 6'd6;
  localparam logic [5:0] R_RE   = 6'd7;
  localparam logic [5:0] R_PT   = 6'd8;
  localparam logic [5:0] R_PR   = 6'd9;
  localparam logic [5:0] R_PI   = 6'd10;
  localparam logic [5:0] R_I    = 6'd11;
  localparam logic [5:0] R_X    = 6'd16;
  localparam logic [5:0] R_Y    = 6'd17;
  localparam logic [5:0] R_AUC  = 6'd19;
  localparam logic [5:0] R_PSW  = 6'd20;
  localparam logic [5:0] R_C0   = 6'd21;
  localparam logic [5:0] R_C1   = 6'd22;
  localparam logic [5:0] R_C2   = 6'd23;
  localparam logic [5:0] R_PDX0 = 6'd29;
  localparam logic [5:0] R_PDX1 = 6'd30;

  typedef enum logic {
    WORD1 = 1'b0,
    WORD2 = 1'b1
  } dec_state_e;

  // Codes backed by a 16-bit storage register (pdx codes go to the port instead).
  function automatic logic is_reg_code(input logic [5:0] code);
    return (code <= R_I) || (code == R_X) || (code == R_Y) ||
           ((code >= R_AUC) && (code <= R_C2));
  endfunction

  function automatic logic is_pdx_code(input logic [5:0] code);
    return (code == R_PDX0) || (code == R_PDX1);
  endfunction

endpackage

// File: rtl/dsp16_regs.sv
// Register file (RAM-AAU, ROM-AAU, DAU) with write decode by R code, the
// multiplier/accumulator path and the parallel-output strobe.
module dsp16_regs
  import dsp16_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic        wr_en,
  input  logic [5:0]  wr_addr,
  input  logic [15:0] wr_data,
  input  logic        mpy_en,
  output logic [15:0] pbus_out,
  output logic        pods_n,
  output logic        psel
);

  localparam logic [4:0] X_IDX = R_X[4:0];
  localparam logic [4:0] Y_IDX = R_Y[4:0];

  // 16-bit registers indexed directly by the low five bits of their R code.
  logic [31:0][15:0] reg_q, reg_d;
  logic [31:0]       p_q, p_d;
  logic [35:0]       a0_q, a0_d;
  logic [35:0]       a1_q, a1_d;
  logic [15:0]       pbus_out_q, pbus_out_d;
  logic              pods_n_q, pods_n_d;
  logic              psel_q, psel_d;
  logic signed [31:0] prod;

  always_comb begin
    reg_d      = reg_q;
    p_d        = p_q;
    a0_d       = a0_q;
    a1_d       = a1_q;
    pbus_out_d = pbus_out_q;
    psel_d     = psel_q;
    pods_n_d   = 1'b1;
    prod       = $signed(reg_q[X_IDX]) * $signed(reg_q[Y_IDX]);

    if (wr_en) begin
      if (is_reg_code(wr_addr)) begin
        reg_d[wr_addr[4:0]] = wr_data;
      end
      if (is_pdx_code(wr_addr)) begin
        pbus_out_d = wr_data;
        psel_d     = ~wr_addr[0];
        pods_n_d   = 1'b0;
      end
    end

    // a0 takes the product register as it stood before this multiply.
    if (mpy_en) begin
      p_d  = prod;
      a0_d = {{4{p_q[31]}}, p_q};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_q      <= '0;
      p_q        <= '0;
      a0_q       <= '0;
      a1_q       <= '0;
      pbus_out_q <= '0;
      pods_n_q   <= 1'b1;
      psel_q     <= 1'b0;
    end else if (cen) begin
      reg_q      <= reg_d;
      p_q        <= p_d;
      a0_q       <= a0_d;
      a1_q       <= a1_d;
      pbus_out_q <= pbus_out_d;
      pods_n_q   <= pods_n_d;
      psel_q     <= psel_d;
    end
  end

  assign pbus_out = pbus_out_q;
  assign pods_n   = pods_n_q;
  assign psel     = psel_q;

endmodule

// File: rtl/dsp16_core.sv
// Reduced DSP16 core: byte-programmable program ROM, pc and two-word decode
// FSM, register file instance and serial/interrupt tie-offs.
module dsp16_core
  import dsp16_pkg::*;
#(
  parameter int ROM_AW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic          ext_mode,
  input  logic [15:0]   pbus_in,
  output logic [15:0]   pbus_out,
  output logic          pods_n,
  output logic          pids_n,
  output logic          psel,
  output logic          sdo,
  output logic          ock,
  output logic          sadd,
  input  logic          irq,
  output logic          iack,
  input  logic [ROM_AW:0] prog_addr,
  input  logic [7:0]    prog_data,
  input  logic          prog_we
);

  logic [15:0] rom [0:(1<<ROM_AW)-1];
  logic [15:0] ins;
  logic [4:0]  op_t;

  logic [15:0] pc_q, pc_d;
  logic [5:0]  rsel_q, rsel_d;
  dec_state_e  state_q, state_d;
  logic        wr_en;
  logic        mpy_en;
  logic        unused_inputs;

  // Programming port is deliberately outside reset and clock enable.
  always_ff @(posedge clk) begin
    if (prog_we) begin
      if (prog_addr[0]) rom[prog_addr[ROM_AW:1]][15:8] <= prog_data;
      else              rom[prog_addr[ROM_AW:1]][7:0]  <= prog_data;
    end
  end

  assign ins  = rom[pc_q[ROM_AW-1:0]];
  assign op_t = ins[15:11];

  always_comb begin
    pc_d    = pc_q + 16'd1;
    rsel_d  = rsel_q;
    state_d = state_q;
    wr_en   = 1'b0;
    mpy_en  = 1'b0;

    if (state_q == WORD2) begin
      wr_en   = 1'b1;
      state_d = WORD1;
    end else begin
      case (op_t)
        T_GOTO0, T_GOTO1: pc_d = {pc_q[15:12], ins[11:0]};
        T_RLOAD: begin
          rsel_d  = ins[9:4];
          state_d = WORD2;
        end
        T_MPY:   mpy_en = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= '0;
      rsel_q  <= '0;
      state_q <= WORD1;
    end else if (cen) begin
      pc_q    <= pc_d;
      rsel_q  <= rsel_d;
      state_q <= state_d;
    end
  end

  dsp16_regs u_regs (
    .clk      (clk),
    .rst      (rst),
    .cen      (cen),
    .wr_en    (wr_en),
    .wr_addr  (rsel_q),
    .wr_data  (ins),
    .mpy_en   (mpy_en),
    .pbus_out (pbus_out),
    .pods_n   (pods_n),
    .psel     (psel)
  );

  assign pids_n = 1'b1;
  assign sdo    = 1'b0;
  assign ock    = 1'b0;
  assign sadd   = 1'b1;
  assign iack   = 1'b0;

  assign unused_inputs = ^{ext_mode, irq, pbus_in};

endmodule

// File: tb/tb_dsp16_core.sv
// Scoreboard bench for dsp16_core: expected register values and parallel-port
// writes are queued as programs are loaded and drained as the core produces them.
module tb_dsp16_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cen = 1'b1;
  logic        ext_mode = 1'b0;
  logic [15:0] pbus_in = 16'h0;
  logic [15:0] pbus_out;
  logic        pods_n, pids_n, psel, sdo, ock, sadd, iack;
  logic        irq = 1'b0;
  logic [12:0] prog_addr = '0;
  logic [7:0]  prog_data = '0;
  logic        prog_we = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int pod_lows = 0;

  typedef struct { logic [4:0] code; logic [15:0] val; } reg_exp_t;
  typedef struct { logic [15:0] dat; logic sel; } pdx_exp_t;
  reg_exp_t reg_sb[$];
  pdx_exp_t pdx_sb[$];

  dsp16_core dut (
    .clk(clk), .rst(rst), .cen(cen), .ext_mode(ext_mode),
    .pbus_in(pbus_in), .pbus_out(pbus_out), .pods_n(pods_n), .pids_n(pids_n),
    .psel(psel), .sdo(sdo), .ock(ock), .sadd(sadd), .irq(irq), .iack(iack),
    .prog_addr(prog_addr), .prog_data(prog_data), .prog_we(prog_we)
  );

  always #5 clk = ~clk;

  // Every observed output strobe consumes one queued expected write.
  always @(negedge clk) begin
    if (pods_n === 1'b0) begin
      pdx_exp_t e;
      pod_lows++;
      n_checks++;
      if (pdx_sb.size() == 0) begin
        n_fail++;
        $display("FAIL pdx_unexpected: pbus_out=%h psel=%b with no write expected", pbus_out, psel);
      end else begin
        e = pdx_sb.pop_front();
        if (pbus_out !== e.dat || psel !== e.sel || pids_n !== 1'b1) begin
          n_fail++;
          $display("FAIL pdx_write: got pbus_out=%h psel=%b pids_n=%b expected %h %b 1",
                   pbus_out, psel, pids_n, e.dat, e.sel);
        end
      end
    end
  end

  task automatic prog_word(input logic [11:0] a, input logic [15:0] d);
    prog_we   = 1'b1;
    prog_addr = {a, 1'b0};
    prog_data = d[7:0];
    @(negedge clk);
    prog_addr = {a, 1'b1};
    prog_data = d[15:8];
    @(negedge clk);
    prog_we   = 1'b0;
  endtask

  task automatic load_prog1();
    prog_word(12'd0, 16'h5000);
    prog_word(12'd1, 16'h1234);
    prog_word(12'd2, 16'h5010);
    prog_word(12'd3, 16'hBEEF);
    prog_word(12'd4, 16'h0004);
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cen = 1'b1;
    @(negedge clk);
    n_checks++;
    if (dut.pc_q !== 16'h0 || dut.state_q !== dsp16_pkg::WORD1) begin
      n_fail++; $display("FAIL reset_pc_state: pc=%h state=%b expected 0000 0", dut.pc_q, dut.state_q);
    end
    n_checks++;
    if (pbus_out !== 16'h0 || pods_n !== 1'b1 || pids_n !== 1'b1 || psel !== 1'b0) begin
      n_fail++; $display("FAIL reset_port: pbus_out=%h pods_n=%b pids_n=%b psel=%b expected 0000 1 1 0",
                         pbus_out, pods_n, pids_n, psel);
    end
    n_checks++;
    if (sdo !== 1'b0 || ock !== 1'b0 || sadd !== 1'b1 || iack !== 1'b0) begin
      n_fail++; $display("FAIL tieoffs: sdo=%b ock=%b sadd=%b iack=%b expected 0 0 1 0", sdo, ock, sadd, iack);
    end
    n_checks++;
    if (dut.u_regs.reg_q !== '0 || dut.u_regs.p_q !== 32'h0 ||
        dut.u_regs.a0_q !== 36'h0 || dut.u_regs.a1_q !== 36'h0) begin
      n_fail++; $display("FAIL reset_regs: p=%h a0=%h a1=%h expected all zero",
                         dut.u_regs.p_q, dut.u_regs.a0_q, dut.u_regs.a1_q);
    end
  endtask

  task automatic test_load_goto();
    rst = 1'b1;
    load_prog1();
    reg_sb.push_back('{5'd0, 16'h1234});
    reg_sb.push_back('{5'd1, 16'hBEEF});
    rst = 1'b0;
    run(20);
    while (reg_sb.size() > 0) begin
      reg_exp_t e = reg_sb.pop_front();
      n_checks++;
      if (dut.u_regs.reg_q[e.code] !== e.val) begin
        n_fail++; $display("FAIL load_reg%0d: got %h expected %h", e.code, dut.u_regs.reg_q[e.code], e.val);
      end
    end
    run(3);
    n_checks++;
    if (dut.pc_q !== 16'h0004) begin
      n_fail++; $display("FAIL goto_self_pc: got %h expected 0004", dut.pc_q);
    end
  endtask

  task automatic test_mpy();
    rst = 1'b1;
    prog_word(12'd0, 16'h5100);
    prog_word(12'd1, 16'h0003);
    prog_word(12'd2, 16'h5110);
    prog_word(12'd3, 16'hFFFE);
    prog_word(12'd4, 16'h3000);
    prog_word(12'd5, 16'h3000);
    prog_word(12'd6, 16'h0006);
    rst = 1'b0;
    run(20);
    n_checks++;
    if (dut.u_regs.p_q !== 32'hFFFF_FFFA) begin
      n_fail++; $display("FAIL mpy_p: got %h expected fffffffa", dut.u_regs.p_q);
    end
    n_checks++;
    if (dut.u_regs.a0_q !== 36'hF_FFFF_FFFA) begin
      n_fail++; $display("FAIL mpy_a0: got %h expected ffffffffa", dut.u_regs.a0_q);
    end
    n_checks++;
    if (dut.u_regs.reg_q[16] !== 16'h0003 || dut.u_regs.reg_q[17] !== 16'hFFFE || dut.pc_q !== 16'h0006) begin
      n_fail++; $display("FAIL mpy_xy_pc: x=%h y=%h pc=%h expected 0003 fffe 0006",
                         dut.u_regs.reg_q[16], dut.u_regs.reg_q[17], dut.pc_q);
    end
  endtask

  task automatic test_pdx();
    rst = 1'b1;
    prog_word(12'd0, 16'h51E0);
    prog_word(12'd1, 16'hCAFE);
    prog_word(12'd2, 16'h51D0);
    prog_word(12'd3, 16'h1234);
    prog_word(12'd4, 16'h0004);
    pdx_sb.push_back('{16'hCAFE, 1'b1});
    pdx_sb.push_back('{16'h1234, 1'b0});
    pod_lows = 0;
    rst = 1'b0;
    run(20);
    n_checks++;
    if (pdx_sb.size() != 0 || pod_lows != 2) begin
      n_fail++; $display("FAIL pdx_strobe_count: pending=%0d low_cycles=%0d expected 0 2", pdx_sb.size(), pod_lows);
      pdx_sb.delete();
    end
    n_checks++;
    if (pods_n !== 1'b1 || pids_n !== 1'b1 || pbus_out !== 16'h1234 || psel !== 1'b0) begin
      n_fail++; $display("FAIL pdx_idle: pods_n=%b pids_n=%b pbus_out=%h psel=%b expected 1 1 1234 0",
                         pods_n, pids_n, pbus_out, psel);
    end
  endtask

  task automatic test_cen_freeze();
    rst = 1'b1;
    load_prog1();
    rst = 1'b0;
    run(3);
    cen = 1'b0;
    run(10);
    n_checks++;
    if (dut.pc_q !== 16'h0003 || dut.state_q !== dsp16_pkg::WORD2 ||
        dut.u_regs.reg_q[0] !== 16'h1234 || dut.u_regs.reg_q[1] !== 16'h0000) begin
      n_fail++; $display("FAIL cen_frozen: pc=%h state=%b r0=%h r1=%h expected 0003 1 1234 0000",
                         dut.pc_q, dut.state_q, dut.u_regs.reg_q[0], dut.u_regs.reg_q[1]);
    end
    cen = 1'b1;
    run(20);
    n_checks++;
    if (dut.pc_q !== 16'h0004 || dut.u_regs.reg_q[0] !== 16'h1234 || dut.u_regs.reg_q[1] !== 16'hBEEF) begin
      n_fail++; $display("FAIL cen_resume: pc=%h r0=%h r1=%h expected 0004 1234 beef",
                         dut.pc_q, dut.u_regs.reg_q[0], dut.u_regs.reg_q[1]);
    end
  endtask

  task automatic test_rst_abort();
    rst = 1'b1;
    prog_word(12'd0, 16'h5030);
    prog_word(12'd1, 16'h7777);
    prog_word(12'd2, 16'h0002);
    rst = 1'b0;
    run(1);
    n_checks++;
    if (dut.pc_q !== 16'h0001 || dut.state_q !== dsp16_pkg::WORD2) begin
      n_fail++; $display("FAIL abort_setup: pc=%h state=%b expected 0001 1", dut.pc_q, dut.state_q);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (dut.u_regs.reg_q[3] !== 16'h0 || dut.pc_q !== 16'h0 || pods_n !== 1'b1 ||
        dut.state_q !== dsp16_pkg::WORD1) begin
      n_fail++; $display("FAIL abort_async: r3=%h pc=%h pods_n=%b state=%b expected 0000 0000 1 0",
                         dut.u_regs.reg_q[3], dut.pc_q, pods_n, dut.state_q);
    end
    run(2);
    n_checks++;
    if (dut.u_regs.reg_q[3] !== 16'h0 || dut.pc_q !== 16'h0) begin
      n_fail++; $display("FAIL abort_held: r3=%h pc=%h expected 0000 0000", dut.u_regs.reg_q[3], dut.pc_q);
    end
  endtask

  task automatic test_all_regs();
    int codes[13] = '{4, 5, 6, 7, 8, 9, 10, 11, 19, 20, 21, 22, 23};
    int bad[2]    = '{12, 18};
    int addr = 0;
    logic [15:0] w;
    rst = 1'b1;
    foreach (codes[n]) begin
      w = 16'h5000 | (16'(codes[n]) << 4);
      prog_word(12'(addr), w);
      prog_word(12'(addr + 1), 16'h0101 * 16'(codes[n]));
      reg_sb.push_back('{5'(codes[n]), 16'h0101 * 16'(codes[n])});
      addr += 2;
    end
    foreach (bad[n]) begin
      w = 16'h5000 | (16'(bad[n]) << 4);
      prog_word(12'(addr), w);
      prog_word(12'(addr + 1), 16'hFFFF);
      reg_sb.push_back('{5'(bad[n]), 16'h0000});
      addr += 2;
    end
    for (int c = 0; c < 4; c++) reg_sb.push_back('{5'(c), 16'h0000});
    reg_sb.push_back('{5'd16, 16'h0000});
    reg_sb.push_back('{5'd17, 16'h0000});
    prog_word(12'(addr), 16'(addr));
    rst = 1'b0;
    run(50);
    while (reg_sb.size() > 0) begin
      reg_exp_t e = reg_sb.pop_front();
      n_checks++;
      if (dut.u_regs.reg_q[e.code] !== e.val) begin
        n_fail++; $display("FAIL regcode_%0d: got %h expected %h", e.code, dut.u_regs.reg_q[e.code], e.val);
      end
    end
    n_checks++;
    if (dut.pc_q !== 16'(addr) || dut.u_regs.p_q !== 32'h0 || dut.u_regs.a0_q !== 36'h0 ||
        dut.u_regs.a1_q !== 36'h0) begin
      n_fail++; $display("FAIL regs_side: pc=%h p=%h a0=%h a1=%h expected %h 0 0 0",
                         dut.pc_q, dut.u_regs.p_q, dut.u_regs.a0_q, dut.u_regs.a1_q, 16'(addr));
    end
  endtask

  initial begin
    test_reset();
    test_load_goto();
    test_mpy();
    test_pdx();
    test_cen_freeze();
    test_rst_abort();
    test_all_regs();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
